// File: rtl/rs_dec_sched_16_8.sv
// Stage scheduler for the RS(16,8) decoder: issues KES/Chien/Forney/output start pulses once inputs
// have settled and result registers are free; flags syndrome overruns, spurious dones and hung stages.
module rs_dec_sched_16_8 #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             synd_val_i,
    input  logic [3:0]       stg_done_i,
    input  logic             clr_err_i,
    output logic [3:0]       stg_start_o,
    output logic [3:0]       stg_busy_o,
    output logic             idle_o,
    output logic [CNT_W-1:0] frame_in_cnt_o,
    output logic [CNT_W-1:0] frame_out_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             overrun_o,
    output logic [3:0]       spur_o,
    output logic [3:0]       tmo_o
);

    localparam int unsigned     TmoW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast    = TmoW'(TIMEOUT - 1);
    localparam logic [2:0]      SettleLoad = 3'(SETTLE_CYC - 1);

    logic [3:0]            avail_q, avail_d;
    logic [3:0]            busy_q, busy_d;
    logic [2:0]            res_q, res_d;
    logic [3:0][2:0]       settle_q, settle_d;
    logic [3:0][TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]      frame_in_q, frame_in_d;
    logic [CNT_W-1:0]      frame_out_q, frame_out_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic                  overrun_q, overrun_d;
    logic [3:0]            spur_q, spur_d;
    logic [3:0]            tmo_q, tmo_d;

    logic [3:0] acc_done;
    logic [3:0] tmo_hit;
    logic [3:0] start;
    logic [3:0] trig;
    logic [3:0] res_free;
    logic       overrun_new;
    logic       rel_01;
    logic       rel_2;

    always_comb begin
        acc_done = stg_done_i & busy_q;
        res_free = {1'b1, ~res_q};
        tmo_hit  = '0;
        start    = '0;
        for (int k = 0; k < 4; k++) begin
            // A done arriving in the last allowed cycle still counts as a normal completion.
            tmo_hit[k] = busy_q[k] & ~stg_done_i[k] & (tmo_cnt_q[k] == TmoLast);
            start[k]   = avail_q[k] & (settle_q[k] == 3'd0) & ~busy_q[k] & res_free[k];
        end
        trig = {acc_done[2:0], synd_val_i};
        // A syndrome arriving as the pending one starts is a fresh frame, not an overrun.
        overrun_new = synd_val_i & avail_q[0] & ~start[0];
        rel_01      = acc_done[2] | tmo_hit[2];
        rel_2       = acc_done[3] | tmo_hit[3];
    end

    always_comb begin
        avail_d   = avail_q;
        busy_d    = busy_q;
        settle_d  = settle_q;
        tmo_cnt_d = tmo_cnt_q;
        for (int k = 0; k < 4; k++) begin
            avail_d[k] = (avail_q[k] & ~start[k]) | trig[k];
            busy_d[k]  = start[k] | (busy_q[k] & ~acc_done[k] & ~tmo_hit[k]);
            if (trig[k]) begin
                settle_d[k] = SettleLoad;
            end else if (settle_q[k] != 3'd0) begin
                settle_d[k] = settle_q[k] - 3'd1;
            end
            if (start[k]) begin
                tmo_cnt_d[k] = '0;
            end else if (busy_q[k]) begin
                tmo_cnt_d[k] = tmo_cnt_q[k] + TmoW'(1);
            end
        end
        res_d[0] = acc_done[0] | (res_q[0] & ~rel_01);
        res_d[1] = acc_done[1] | (res_q[1] & ~rel_01);
        res_d[2] = acc_done[2] | (res_q[2] & ~rel_2);

        frame_in_d  = frame_in_q + CNT_W'(synd_val_i);
        frame_out_d = frame_out_q + CNT_W'(acc_done[3]);
        drop_d      = drop_q + CNT_W'(overrun_new);

        overrun_d = (overrun_q & ~clr_err_i) | overrun_new;
        spur_d    = (spur_q & {4{~clr_err_i}}) | (stg_done_i & ~busy_q);
        tmo_d     = (tmo_q & {4{~clr_err_i}}) | tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avail_q     <= '0;
            busy_q      <= '0;
            res_q       <= '0;
            settle_q    <= '0;
            tmo_cnt_q   <= '0;
            frame_in_q  <= '0;
            frame_out_q <= '0;
            drop_q      <= '0;
            overrun_q   <= 1'b0;
            spur_q      <= '0;
            tmo_q       <= '0;
        end else begin
            avail_q     <= avail_d;
            busy_q      <= busy_d;
            res_q       <= res_d;
            settle_q    <= settle_d;
            tmo_cnt_q   <= tmo_cnt_d;
            frame_in_q  <= frame_in_d;
            frame_out_q <= frame_out_d;
            drop_q      <= drop_d;
            overrun_q   <= overrun_d;
            spur_q      <= spur_d;
            tmo_q       <= tmo_d;
        end
    end

    assign stg_start_o     = start;
    assign stg_busy_o      = busy_q;
    assign idle_o          = ~(|busy_q | |avail_q | |res_q);
    assign frame_in_cnt_o  = frame_in_q;
    assign frame_out_cnt_o = frame_out_q;
    assign drop_cnt_o      = drop_q;
    assign overrun_o       = overrun_q;
    assign spur_o          = spur_q;
    assign tmo_o           = tmo_q;

endmodule
